// File: rtl/req_prio_encoder.sv
// req_prio_encoder: sticky request collector with registered valid/ready index output.
// Requests are ORed into a pending mask; one pending index at a time is granted
// to a single consumer. Selection is lowest-index-first by default; defining
// REQ_PRIO_ROUND_ROBIN_EN switches to round-robin selection starting at rr_ptr.
module req_prio_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending,
  output logic             busy,
  output logic             dup_drop
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] sel;
  logic             load;
  logic [WIDTH-1:0] take_mask;
  logic [WIDTH-1:0] incoming;
  logic [WIDTH-1:0] pending_nxt;
  logic             dup_nxt;

  // Index of the lowest set bit of v (0 when v is empty).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    lowest_set = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

`ifdef REQ_PRIO_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   rr_ptr;
  logic [2*WIDTH-1:0] doubled;
  logic [WIDTH-1:0]   rotated;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     wrapped;

  // Rotate pending so rr_ptr lands at bit 0, find first set bit, rotate back.
  always_comb begin
    doubled = {pending, pending} >> rr_ptr;
    rotated = doubled[WIDTH-1:0];
    offset  = lowest_set(rotated);
    wrapped = {1'b0, rr_ptr} + {1'b0, offset};
    if (32'(wrapped) >= WIDTH) wrapped = wrapped - (IDX_W+1)'(WIDTH);
    sel = wrapped[IDX_W-1:0];
  end

  // Pointer moves just past each granted index, wrapping at WIDTH-1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= (32'(sel) == WIDTH - 1) ? '0 : sel + 1'b1;
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    sel = lowest_set(pending);
  end
`endif

  // Next-state, grant and pending-mask update.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    take_mask   = '0;
    incoming    = req_valid ? req_in : '0;

    case (state)
      IDLE: begin
        if (|pending) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (|pending) load = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) take_mask = WIDTH'(1) << sel;
    pending_nxt = (pending & ~take_mask) | incoming;
    dup_nxt     = |(incoming & pending & ~take_mask);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      dup_drop  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      out_valid <= (state_nxt == HOLD);
      if (load) out_idx <= sel;
      dup_drop  <= dup_nxt;
      busy      <= (state_nxt == HOLD) | (|pending_nxt);
    end
  end

endmodule

// File: tb/tb_req_prio_encoder.sv
// Self-checking bench for req_prio_encoder (define REQ_PRIO_ROUND_ROBIN_EN for the round-robin build).
module tb_req_prio_encoder;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic [W-1:0]  req_in;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [W-1:0]  pending;
  logic          busy;
  logic          dup_drop;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [W-1:0]  m_pend;
  logic          m_valid;
  logic [IW-1:0] m_idx;
  logic          m_dup;
  int            m_rr;

  always #5 clk = ~clk;

  req_prio_encoder #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_in    (req_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .busy      (busy),
    .dup_drop  (dup_drop)
  );

  // Which pending index the selection rule picks.
  function automatic int pick(input logic [W-1:0] p, input int rr);
    int r;
    r = 0;
`ifdef REQ_PRIO_ROUND_ROBIN_EN
    for (int k = W - 1; k >= 0; k--) begin
      if (p[(rr + k) % W]) r = (rr + k) % W;
    end
`else
    for (int k = W - 1; k >= 0; k--) begin
      if (p[k]) r = k + 0 * rr;
    end
`endif
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
  task automatic step(input logic rn, input logic rv, input logic [W-1:0] rin, input logic rdy);
    logic [W-1:0] inc;
    logic [W-1:0] take;
    bit           grant;
    int           g;
    resetn    = rn;
    req_valid = rv;
    req_in    = rin;
    out_ready = rdy;
    @(posedge clk);
    if (!rn) begin
      m_pend = '0; m_valid = 1'b0; m_idx = '0; m_dup = 1'b0; m_rr = 0;
    end else begin
      inc   = rv ? rin : '0;
      take  = '0;
      grant = (m_pend != 0) && (!m_valid || rdy);
      if (grant) begin
        g       = pick(m_pend, m_rr);
        take[g] = 1'b1;
        m_idx   = IW'(g);
        m_rr    = (g + 1) % W;
        m_valid = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      m_dup  = (inc & m_pend & ~take) != 0;
      m_pend = (m_pend & ~take) | inc;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({out_valid, out_idx, pending, busy, dup_drop} !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%b idx=%0d pend=%b busy=%b dup=%b want all zero",
               out_valid, out_idx, pending, busy, dup_drop);
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b1, 8'b0000_0001, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h01) begin
      failures++;
      $display("FAIL single_capture got v=%b pend=%b want v=0 pend=00000001", out_valid, pending);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got v=%b idx=%0d pend=%b busy=%b want v=1 idx=0 pend=0 busy=1",
               out_valid, out_idx, pending, busy);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done got v=%b busy=%b want v=0 busy=0", out_valid, busy);
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b1, W'(1) << i, 1'b1);
      step(1'b1, 1'b0, '0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(i)) begin
        failures++;
        $display("FAIL walk_%0d got v=%b idx=%0d want v=1 idx=%0d", i, out_valid, out_idx, i);
      end
      step(1'b1, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_multi();
    int exp_seq[3];
`ifdef REQ_PRIO_ROUND_ROBIN_EN
    exp_seq = '{7, 1, 4};
`else
    exp_seq = '{1, 4, 7};
`endif
    // Granting index 4 leaves the round-robin pointer at 5.
    step(1'b1, 1'b1, 8'b0001_0000, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 8'b1001_0010, 1'b1);
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(exp_seq[n])) begin
        failures++;
        $display("FAIL multi_seq%0d got v=%b idx=%0d want v=1 idx=%0d",
                 n, out_valid, out_idx, exp_seq[n]);
      end
    end
    step(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL multi_end got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_hold_dup();
    step(1'b1, 1'b1, 8'b0000_0110, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd1 || pending !== 8'b0000_0100) begin
        failures++;
        $display("FAIL hold_c%0d got v=%b idx=%0d pend=%b want v=1 idx=1 pend=00000100",
                 c, out_valid, out_idx, pending);
      end
    end
    step(1'b1, 1'b1, 8'b0000_0100, 1'b0);
    checks++;
    if (dup_drop !== 1'b1 || pending !== 8'b0000_0100) begin
      failures++;
      $display("FAIL dup_pulse got dup=%b pend=%b want dup=1 pend=00000100", dup_drop, pending);
    end
    step(1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (dup_drop !== 1'b0) begin
      failures++;
      $display("FAIL dup_clear got dup=%b want 0", dup_drop);
    end
    // Held index re-requested: queued, not a duplicate.
    step(1'b1, 1'b1, 8'b0000_0010, 1'b0);
    checks++;
    if (dup_drop !== 1'b0 || pending !== 8'b0000_0110) begin
      failures++;
      $display("FAIL held_rereq got dup=%b pend=%b want dup=0 pend=00000110", dup_drop, pending);
    end
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("FAIL hold_drain got v=%b pend=%b want v=0 pend=0", out_valid, pending);
    end
  endtask

  task automatic test_same_edge();
    step(1'b1, 1'b1, 8'b0000_1000, 1'b0);
    step(1'b1, 1'b1, 8'b0000_1000, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending !== 8'b0000_1000 || dup_drop !== 1'b0) begin
      failures++;
      $display("FAIL same_edge got v=%b idx=%0d pend=%b dup=%b want v=1 idx=3 pend=00001000 dup=0",
               out_valid, out_idx, pending, dup_drop);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending !== 8'h00) begin
      failures++;
      $display("FAIL same_edge_again got v=%b idx=%0d pend=%b want v=1 idx=3 pend=0",
               out_valid, out_idx, pending);
    end
    step(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic test_drain_all();
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    while (out_valid === 1'b1 && guard < 3 * W) begin
      checks++;
      if (out_idx !== m_idx) begin
        failures++;
        $display("FAIL drain_idx%0d got idx=%0d want %0d", cnt, out_idx, m_idx);
      end
      cnt++;
      guard++;
      step(1'b1, 1'b0, '0, 1'b1);
    end
    checks++;
    if (cnt != W || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_count got %0d handshakes v=%b want %0d v=0", cnt, out_valid, W);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || out_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid got v=%b pend=%b idx=%0d want 0 0 0", out_valid, pending, out_idx);
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_quiet_c%0d got v=%b busy=%b want 0 0", c, out_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    logic rn;
    logic rv;
    logic rdy;
    logic [W-1:0] rin;
    for (int c = 0; c < 500; c++) begin
      rn  = ($urandom_range(0, 49) != 0);
      rv  = ($urandom_range(0, 2) == 0);
      rin = ($urandom_range(0, 3) == 0) ? W'(1) << $urandom_range(0, W - 1) : W'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      step(rn, rv, rin, rdy);
      checks++;
      if ({out_valid, out_idx, pending, busy, dup_drop} !==
          {m_valid, m_idx, m_pend, (m_valid || (m_pend != 0)), m_dup}) begin
        failures++;
        $display("FAIL random_c%0d got v=%b idx=%0d pend=%b busy=%b dup=%b want v=%b idx=%0d pend=%b busy=%b dup=%b",
                 c, out_valid, out_idx, pending, busy, dup_drop,
                 m_valid, m_idx, m_pend, (m_valid || (m_pend != 0)), m_dup);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_in = '0; out_ready = 1'b0;
    m_pend = '0; m_valid = 1'b0; m_idx = '0; m_dup = 1'b0; m_rr = 0;
    test_reset();
    test_single();
    test_walk();
    test_multi();
    test_hold_dup();
    test_same_edge();
    test_drain_all();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
